// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Purpose  : Next-PC generator with a direct-mapped BTB of 2-bit saturating
//            counters; EX trains the BTB and redirects fetch on mispredict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic [1:0]       ctr_d;
    logic             unused_lsbs;

    // Byte offset within the word never selects an entry.
    assign unused_lsbs = ^{pc[1:0], upd_pc[1:0]};

    assign w_lk_idx  = pc[IDX_W+1:2];
    assign w_lk_tag  = pc[31:IDX_W+2];
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[31:IDX_W+2];

    assign w_lk_hit    = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    assign pred_taken  = w_lk_hit && ctr_q[w_lk_idx][1];
    assign pred_target = pred_taken ? target_q[w_lk_idx] : 32'd0;

    always_comb begin
        next_pc = pc + 32'd4;
        if (redirect) begin
            next_pc = redirect_pc;
        end else if (pred_taken) begin
            next_pc = pred_target;
        end
    end

    assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);

    always_comb begin
        ctr_d = ctr_q[w_upd_idx];
        if (upd_taken) begin
            if (ctr_q[w_upd_idx] != 2'b11) ctr_d = ctr_q[w_upd_idx] + 2'b01;
        end else begin
            if (ctr_q[w_upd_idx] != 2'b00) ctr_d = ctr_q[w_upd_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            if (w_upd_hit) begin
                ctr_q[w_upd_idx] <= ctr_d;
                if (upd_taken) target_q[w_upd_idx] <= upd_target;
            end else if (upd_taken) begin
                // Taken miss replaces whatever lives here; old counter is lost.
                valid_q[w_upd_idx]  <= 1'b1;
                tag_q[w_upd_idx]    <= w_upd_tag;
                target_q[w_upd_idx] <= upd_target;
                ctr_q[w_upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed plus randomized self-checking bench for branch_predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: one slot per index remembering the full word address
    // of the resident branch, its target and a strength level 0..3.
    bit          m_valid [16];
    bit   [29:0] m_word  [16];
    bit   [31:0] m_tgt   [16];
    int          m_str   [16];

    branch_predictor #(.IDX_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .next_pc     (next_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_word[i]  = 30'd0;
            m_tgt[i]   = 32'd0;
            m_str[i]   = 1;
        end
    endtask

    task automatic model_update(input logic [31:0] a, input logic t, input logic [31:0] tg);
        int  i;
        bit  h;
        i = int'(a[31:2] % 30'd16);
        h = m_valid[i] && (m_word[i] == a[31:2]);
        if (h) begin
            if (t) begin
                m_str[i] = (m_str[i] < 3) ? m_str[i] + 1 : 3;
                m_tgt[i] = tg;
            end else begin
                m_str[i] = (m_str[i] > 0) ? m_str[i] - 1 : 0;
            end
        end else if (t) begin
            m_valid[i] = 1'b1;
            m_word[i]  = a[31:2];
            m_tgt[i]   = tg;
            m_str[i]   = 2;
        end
    endtask

    // One cycle: drive at the falling edge, check just after, then clock.
    task automatic step(input logic r, input logic [31:0] p,
                        input logic rd, input logic [31:0] rdpc,
                        input logic ue, input logic [31:0] up,
                        input logic ut, input logic [31:0] utg);
        int          i;
        logic        e_taken;
        logic [31:0] e_tgt;
        logic [31:0] e_next;
        rst = r; pc = p; redirect = rd; redirect_pc = rdpc;
        upd_en = ue; upd_pc = up; upd_taken = ut; upd_target = utg;
        #1;
        i       = int'(p[31:2] % 30'd16);
        e_taken = m_valid[i] && (m_word[i] == p[31:2]) && (m_str[i] >= 2);
        e_tgt   = e_taken ? m_tgt[i] : 32'd0;
        e_next  = rd ? rdpc : (e_taken ? e_tgt : p + 32'd4);
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
        chk("pred_target", pred_target, e_tgt);
        chk("next_pc", next_pc, e_next);
        @(posedge clk);
        if (r) model_reset();
        else if (ue) model_update(up, ut, utg);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] p);
        step(1'b0, p, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic train(input logic [31:0] p, input logic [31:0] up,
                         input logic ut, input logic [31:0] utg);
        step(1'b0, p, 1'b0, 32'd0, 1'b1, up, ut, utg);
    endtask

    initial begin
        logic [31:0] rp;
        logic [31:0] ru;
        model_reset();
        // First reset edge initialises the array; checks start afterwards.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 32'h10, 1'b1, 32'h88, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(32'h0);
        fetch(32'h4);
        chk("seq_next_pc_const", next_pc, 32'h8);

        train(32'h8, 32'h20, 1'b1, 32'h100);
        fetch(32'h20);
        train(32'h0, 32'h20, 1'b0, 32'h0);
        fetch(32'h20);
        train(32'h0, 32'h20, 1'b1, 32'h100);
        train(32'h0, 32'h20, 1'b1, 32'h100);
        train(32'h0, 32'h20, 1'b1, 32'h100);
        fetch(32'h20);
        train(32'h0, 32'h20, 1'b0, 32'h0);
        fetch(32'h20);

        fetch(32'h60);
        train(32'h0, 32'h60, 1'b0, 32'h0);
        fetch(32'h20);
        train(32'h0, 32'h60, 1'b1, 32'h200);
        fetch(32'h20);
        fetch(32'h60);

        train(32'h0, 32'h20, 1'b1, 32'h100);
        step(1'b0, 32'h20, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(32'hFFFF_FFFC);
        chk("wrap_next_pc_const", next_pc, 32'h0);

        train(32'h30, 32'h30, 1'b1, 32'h300);
        fetch(32'h30);
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h400);
        fetch(32'h40);
        fetch(32'h30);
        fetch(32'h20);

        for (int n = 0; n < 400; n++) begin
            rp = 32'($urandom_range(0, 63) * 4) | ($urandom_range(0, 1) ? 32'h100 : 32'h0);
            ru = 32'($urandom_range(0, 63) * 4) | ($urandom_range(0, 1) ? 32'h100 : 32'h0);
            step(($urandom_range(0, 59) == 0), rp,
                 ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 2) != 0), ru,
                 ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
